// File: rtl/sram_ctrl_pkg.sv
// Shared types for the SRAM request controller: request record and FSM states.
package sram_ctrl_pkg;

  localparam int unsigned SRAM_ADDR_W = 15;
  localparam int unsigned SRAM_DATA_W = 256;

  typedef struct packed {
    logic                   we;
    logic [SRAM_ADDR_W-1:0] addr;
    logic [SRAM_DATA_W-1:0] wdata;
  } sram_req_t;

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; head entry is presented combinationally from storage.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Push into a full FIFO is accepted only when the head leaves on the same edge.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count < (PW+1)'(DEPTH)) || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sram_req_ctrl.sv
// In-order request controller for a single-port synchronous SRAM with
// credit-limited reads and optional zero-fill after reset.
module sram_req_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W    = SRAM_ADDR_W,
  parameter int unsigned DATA_W    = SRAM_DATA_W,
  parameter int unsigned REQ_DEPTH = 4,
  parameter int unsigned RSP_DEPTH = 4,
  parameter int unsigned INIT_EN   = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_din,
  output logic              sram_we,
  output logic              sram_valid_tx,
  input  logic [DATA_W-1:0] sram_dout,
  output logic              init_done
);

  localparam int unsigned RQW = $clog2(REQ_DEPTH) + 1;
  localparam int unsigned RSW = $clog2(RSP_DEPTH) + 1;
  localparam logic [ADDR_W:0] INIT_LAST = {1'b0, {ADDR_W{1'b1}}};

  state_t          state;
  state_t          state_d;
  logic [ADDR_W:0] init_cnt;
  sram_req_t       req_in;
  sram_req_t       head;
  logic [RQW-1:0]  req_count;
  logic [RSW-1:0]  rsp_count;
  logic [RSW:0]    credit_used;
  logic [1:0]      rd_inflight;
  logic            req_push;
  logic            issue;
  logic            rd_issue;
  logic            cap_pend;

  assign req_ready   = (state == S_RUN) && (req_count != RQW'(REQ_DEPTH));
  assign req_push    = req_valid && req_ready;
  assign rsp_valid   = (rsp_count != '0);
  assign credit_used = (RSW+1)'(rd_inflight) + (RSW+1)'(rsp_count);

  always_comb begin
    req_in       = '0;
    req_in.we    = req_we;
    req_in.addr  = SRAM_ADDR_W'(req_addr);
    req_in.wdata = SRAM_DATA_W'(req_wdata);
  end

  always_comb begin
    state_d  = state;
    issue    = 1'b0;
    rd_issue = 1'b0;
    case (state)
      S_INIT: if (init_cnt == INIT_LAST) state_d = S_RUN;
      S_RUN: begin
        // Reads need a guaranteed response slot; writes never consume one.
        issue    = (req_count != '0) && (head.we || (credit_used < (RSW+1)'(RSP_DEPTH)));
        rd_issue = issue && !head.we;
      end
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= (INIT_EN != 0) ? S_INIT : S_RUN;
      init_cnt  <= '0;
      init_done <= 1'b0;
    end else begin
      state     <= state_d;
      init_done <= (state_d == S_RUN);
      if (state == S_INIT) init_cnt <= init_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sram_valid_tx <= 1'b0;
      sram_we       <= 1'b0;
      sram_addr     <= '0;
      sram_din      <= '0;
    end else if (state == S_INIT) begin
      sram_valid_tx <= 1'b1;
      sram_we       <= 1'b1;
      sram_addr     <= init_cnt[ADDR_W-1:0];
      sram_din      <= '0;
    end else if (issue) begin
      sram_valid_tx <= 1'b1;
      sram_we       <= head.we;
      sram_addr     <= head.addr[ADDR_W-1:0];
      if (head.we) sram_din <= head.wdata[DATA_W-1:0];
    end else begin
      sram_valid_tx <= 1'b0;
      sram_we       <= 1'b0;
    end
  end

  // cap_pend marks the edge after the SRAM sampled a read, when sram_dout is valid.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cap_pend    <= 1'b0;
      rd_inflight <= '0;
    end else begin
      cap_pend <= sram_valid_tx && !sram_we;
      case ({rd_issue, cap_pend})
        2'b10:   rd_inflight <= rd_inflight + 1'b1;
        2'b01:   rd_inflight <= rd_inflight - 1'b1;
        default: rd_inflight <= rd_inflight;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH ($bits(sram_req_t)),
    .DEPTH (REQ_DEPTH)
  ) u_req_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (req_push),
    .wdata (req_in),
    .pop   (issue),
    .rdata (head),
    .count (req_count)
  );

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (cap_pend),
    .wdata (sram_dout),
    .pop   (rsp_valid && rsp_ready),
    .rdata (rsp_rdata),
    .count (rsp_count)
  );

endmodule
